// File: rtl/relprime_engine_if.sv
// Start/busy/done handshake bundle for relprime_engine.
// The steps signal exists only when RELPRIME_STEP_COUNT_EN is defined.
interface relprime_engine_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] n_in;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;
`ifdef RELPRIME_STEP_COUNT_EN
  logic [CNT_WIDTH-1:0] steps;

  modport master (output start, n_in, input result, busy, done, err, steps);
  modport slave  (input start, n_in, output result, busy, done, err, steps);
`else
  modport master (output start, n_in, input result, busy, done, err);
  modport slave  (input start, n_in, output result, busy, done, err);
`endif
endinterface

// File: rtl/relprime_engine.sv
// Finds the smallest m >= M_START with gcd(N, m) == 1 using a subtractive Euclid loop.
// Define RELPRIME_STEP_COUNT_EN to add the GCD step counter on bus.steps.
module relprime_engine #(
  parameter int WIDTH     = 16,
  parameter int M_START   = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  relprime_engine_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GCD, S_CHECK, S_DONE} state_t;

  localparam logic [WIDTH-1:0] M_INIT   = WIDTH'(M_START);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_n, r_m, r_a, r_b, r_result;
  logic             r_busy, r_done, r_err;
  logic             w_accept;

  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_m      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_n     <= bus.n_in;
            r_m     <= M_INIT;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          // N == 0 shares a factor with every candidate, so there is no answer
          if (r_n == '0) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_a     <= r_n;
            r_b     <= r_m;
            r_state <= S_GCD;
          end
        end
        S_GCD: begin
          if (r_b == '0) begin
            r_state <= S_CHECK;
          end else if (r_a >= r_b) begin
            r_a <= r_a - r_b;
          end else begin
            r_a <= r_b;
            r_b <= r_a;
          end
        end
        S_CHECK: begin
          if (r_a == WIDTH'(1)) begin
            r_result <= r_m;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_m == ALL_ONES) begin
            // candidate space exhausted; never wrap back to 0
            r_result <= '0;
            r_err    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_m     <= r_m + WIDTH'(1);
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

`ifdef RELPRIME_STEP_COUNT_EN
  logic [CNT_WIDTH-1:0] r_cnt, r_steps;
  logic                 w_enter_done;

  assign w_enter_done = (r_state == S_LOAD && r_n == '0) ||
                        (r_state == S_CHECK && (r_a == WIDTH'(1) || r_m == ALL_ONES));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_steps <= '0;
    end else begin
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == S_GCD && r_b != '0 && r_cnt != '1)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_enter_done)
        r_steps <= r_cnt;
    end
  end

  assign bus.steps = r_steps;
`endif
endmodule

// File: tb/tb_relprime_engine.sv
// Scoreboard bench for relprime_engine: a 16-bit and an 8-bit instance checked against a reference model.
module tb_relprime_engine;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  relprime_engine_if #(.WIDTH(16)) b16();
  relprime_engine_if #(.WIDTH(8))  b8();

  relprime_engine #(.WIDTH(16)) u_dut16 (.CLK(CLK), .RST(RST), .bus(b16));
  relprime_engine #(.WIDTH(8))  u_dut8  (.CLK(CLK), .RST(RST), .bus(b8));

  typedef struct { int res; bit er; longint st; } exp_t;
  exp_t q16[$], q8[$];
  exp_t e16, e8, em;
  int nchk = 0, nerr = 0;
  int dn16 = 0, dn8 = 0, ac16 = 0, ac8 = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_mod(input int x, input int y);
    int a = x, b = y, t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Result via modulo gcd; steps counted as subtractive iterations with b != 0
  function automatic exp_t ref_model(input int n, input int w);
    exp_t r;
    int a, b, t;
    r.res = 0; r.er = 1'b1; r.st = 0;
    if (n == 0) return r;
    for (int m = 2; m < (1 << w); m++) begin
      a = n; b = m;
      while (b != 0) begin
        r.st++;
        if (a >= b) a = a - b;
        else begin t = a; a = b; b = t; end
      end
      if (gcd_mod(n, m) == 1) begin r.res = m; r.er = 1'b0; return r; end
    end
    return r;
  endfunction

  always @(negedge CLK) begin
    if (!RST && b16.done) begin
      dn16++;
      chk("q16_has_entry", q16.size() != 0, 1);
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        chk("res16", b16.result, e16.res);
        chk("err16", b16.err, e16.er);
`ifdef RELPRIME_STEP_COUNT_EN
        chk("steps16", b16.steps, e16.st);
`endif
      end
    end
    if (!RST && b8.done) begin
      dn8++;
      chk("q8_has_entry", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("res8", b8.result, e8.res);
        chk("err8", b8.err, e8.er);
      end
    end
  end

  task automatic go16(input int n);
    @(negedge CLK);
    b16.start = 1'b1; b16.n_in = 16'(n);
    em = ref_model(n, 16); q16.push_back(em); ac16++;
    @(negedge CLK);
    b16.start = 1'b0;
  endtask

  task automatic go8(input int n);
    @(negedge CLK);
    b8.start = 1'b1; b8.n_in = 8'(n);
    em = ref_model(n, 8); q8.push_back(em); ac8++;
    @(negedge CLK);
    b8.start = 1'b0;
  endtask

  task automatic wait_done(input bit w8, input string tag);
    int cyc = 0;
    while ((w8 ? dn8 : dn16) < (w8 ? ac8 : ac16) && cyc < 40000) begin
      @(negedge CLK); cyc++;
    end
    chk(tag, w8 ? dn8 : dn16, w8 ? ac8 : ac16);
  endtask

  initial begin
    int snap, cyc;
    b16.start = 1'b0; b16.n_in = '0;
    b8.start  = 1'b0; b8.n_in  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_result", b16.result, 0);
    chk("rst_busy", b16.busy, 0);
    chk("rst_done", b16.done, 0);
    chk("rst_err", b16.err, 0);
    RST = 1'b0;

    // asynchronous reset mid-run aborts without a done pulse
    go16(12000);
    repeat (50) @(negedge CLK);
    chk("run_busy", b16.busy, 1);
    snap = dn16;
    RST = 1'b1;
    #1;
    chk("abort_busy", b16.busy, 0);
    chk("abort_result", b16.result, 0);
    chk("abort_err", b16.err, 0);
    q16.delete(); ac16--;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_nodone", dn16, snap);
    go16(9);
    wait_done(1'b0, "done_9");
    chk("res_9", b16.result, 2);

    // start held for two cycles is a single request
    @(negedge CLK);
    b16.start = 1'b1; b16.n_in = 16'd12000;
    em = ref_model(12000, 16); q16.push_back(em); ac16++;
    @(negedge CLK); @(negedge CLK);
    b16.start = 1'b0;
    wait_done(1'b0, "done_12000");
    chk("res_12000", b16.result, 7);
    @(negedge CLK);
    chk("busy_after_done", b16.busy, 0);
    chk("single_done_12000", dn16, ac16);

    // back-to-back: restart in the DONE cycle
    go16(5040);
    cyc = 0;
    while (!b16.done && cyc < 40000) begin @(negedge CLK); cyc++; end
    chk("done_5040_seen", b16.done, 1);
    b16.start = 1'b1; b16.n_in = 16'd1;
    em = ref_model(1, 16); q16.push_back(em); ac16++;
    @(negedge CLK);
    b16.start = 1'b0;
    chk("b2b_busy", b16.busy, 1);
    wait_done(1'b0, "done_b2b");
    chk("res_1", b16.result, 2);
`ifdef RELPRIME_STEP_COUNT_EN
    chk("steps_1", b16.steps, 4);
`endif

    // N == 0 reports an error quickly
    go16(0);
    cyc = 0;
    while (!b16.done && cyc < 3) begin @(negedge CLK); cyc++; end
    chk("n0_fast_done", b16.done, 1);
    chk("n0_err", b16.err, 1);
    wait_done(1'b0, "done_0");

    // start during a run is ignored
    go16(5040);
    repeat (20) @(negedge CLK);
    b16.start = 1'b1; b16.n_in = 16'd3;
    @(negedge CLK);
    b16.start = 1'b0;
    wait_done(1'b0, "done_5040");
    repeat (5) @(negedge CLK);
    chk("res_5040", b16.result, 11);
    chk("ignored_start_done_cnt", dn16, ac16);

    // 8-bit instance: fixed and random operands
    go8(210);
    wait_done(1'b1, "done8_210");
    chk("res8_210", b8.result, 11);
    for (int i = 0; i < 40; i++) begin
      go8(int'($urandom_range(1, 255)));
      wait_done(1'b1, "done8_rand");
    end

    repeat (5) @(negedge CLK);
    chk("q16_empty", q16.size(), 0);
    chk("q8_empty", q8.size(), 0);
    chk("done16_total", dn16, ac16);
    chk("done8_total", dn8, ac8);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
